fpga_cmd_decoder: RTL and testbench
===================================

FPGA_CMD_DECODER -- requirements
Module: fpga_cmd_decoder

Interface
REQ-001 SHALL have parameter DIV_RESET, default 8'd95, reset value of divisor (125 kHz LF).
REQ-002 SHALL have parameter THR_RESET, default 8'd127, reset value of threshold.
REQ-003 ck_1356meg  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ncs  in  1  ARM SPI chip select, active low, asynchronous to ck_1356meg.
REQ-006 spck  in  1  ARM SPI clock, asynchronous; data valid on its rising edge.
REQ-007 mosi  in  1  ARM SPI data, MSB first, asynchronous.
REQ-008 major_mode  out  4  mode select; drives the 16:1 output mux select.
REQ-009 minor_mode  out  4  per-mode sub-configuration.
REQ-010 divisor  out  8  LF clock divisor.
REQ-011 threshold  out  8  edge-detect threshold.
REQ-012 cmd_valid  out  1  one-cycle pulse, accepted command applied.
REQ-013 frame_err  out  1  one-cycle pulse, frame rejected.

Function
REQ-014 SHALL synchronise ncs, spck and mosi each through two flops, plus a third flop on ncs and spck for edge detection.
REQ-015 spck_rise = synced spck 1 and delayed 0; ncs_fall / ncs_rise defined likewise on synced ncs.
REQ-016 FSM states: IDLE, SHIFT.
REQ-017 IDLE -> SHIFT on ncs_fall; shift register and bit counter cleared to 0 on that cycle.
REQ-018 In SHIFT, each spck_rise shifts synced mosi into bit 0 of 16-bit shift register (MSB first) and increments the 5-bit bit counter, counter saturating at 17.
REQ-019 spck_rise in IDLE SHALL be ignored.
REQ-020 SHIFT -> IDLE on ncs_rise; the word is decoded that cycle, outputs update on the next edge (1-cycle latency from ncs_rise).
REQ-021 ncs_rise and spck_rise in the same cycle: ncs_rise wins, that bit is discarded.
REQ-022 Frame accepted only if bit counter == 16 at ncs_rise; otherwise frame_err pulses, no output changes.
REQ-023 Opcode = word[15:12]; 4'h1 SET_CONF: major_mode <= word[3:0], minor_mode <= word[7:4].
REQ-024 4'h2 SET_DIVISOR: divisor <= word[7:0]; 4'h3 SET_THRESH: threshold <= word[7:0].
REQ-025 Any other opcode on a 16-bit frame: frame_err pulses, no output changes.
REQ-026 Accepted opcode: cmd_valid pulses exactly one cycle, simultaneous with the updated output value.
REQ-027 cmd_valid and frame_err SHALL never be high in the same cycle.
REQ-028 Configuration outputs are registered and hold value between commands; unused payload bits ignored.
REQ-029 ncs_fall while in SHIFT (glitch) SHALL restart the frame: counter and shift register cleared.

Reset
REQ-030 rst SHALL force: FSM IDLE, shift register 0, counter 0, sync flops 1 for ncs and 0 for spck/mosi, major_mode 0, minor_mode 0, divisor DIV_RESET, threshold THR_RESET, cmd_valid 0, frame_err 0.
REQ-031 rst asserted mid-frame SHALL discard the partial frame; a frame already in progress when rst deasserts SHALL be ignored until the next ncs_fall.

Verification
REQ-032 After rst: major_mode 0, minor_mode 0, divisor 95, threshold 127, no pulses.
REQ-033 Frame 0x1035, 16 bits -> major_mode 5, minor_mode 3, cmd_valid one pulse 1 cycle after ncs_rise.
REQ-034 Frame 0x2058 -> divisor 88, cmd_valid pulse; Frame 0x30C0 -> threshold 192, cmd_valid pulse; major_mode unchanged.
REQ-035 15-bit frame and 17-bit frame of SET_CONF -> frame_err pulse each, major_mode unchanged.
REQ-036 Frame 0x7FFF -> frame_err pulse, all outputs unchanged.
REQ-037 rst pulsed after 8 bits of 0x1035, ncs then raised -> no cmd_valid, no frame_err, outputs at reset values.

Source files
------------

// File: rtl/fpga_cmd_decoder.sv
// ============================================================================
// fpga_cmd_decoder : ARM SPI command decoder for FPGA mode/divisor/threshold
// Revision 1.0
// ============================================================================
`default_nettype none

module fpga_cmd_decoder #(
  parameter logic [7:0] DIV_RESET = 8'd95,
  parameter logic [7:0] THR_RESET = 8'd127
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       ncs,
  input  logic       spck,
  input  logic       mosi,
  output logic [3:0] major_mode,
  output logic [3:0] minor_mode,
  output logic [7:0] divisor,
  output logic [7:0] threshold,
  output logic       cmd_valid,
  output logic       frame_err
);

  localparam logic [3:0] OP_SET_CONF    = 4'h1;
  localparam logic [3:0] OP_SET_DIVISOR = 4'h2;
  localparam logic [3:0] OP_SET_THRESH  = 4'h3;
  localparam logic [4:0] CNT_FULL       = 5'd16;
  localparam logic [4:0] CNT_SAT        = 5'd17;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [2:0]  ncs_sync;
  logic [2:0]  spck_sync;
  logic [1:0]  mosi_sync;
  logic [15:0] shreg, shreg_next;
  logic [4:0]  cnt, cnt_next;
  logic        live;
  logic        armed;

  logic        ncs_fall, ncs_rise, spck_rise;
  logic        frame_done;
  logic        len_ok, op_known;
  logic        accept, reject;
  logic [3:0]  opcode;

  // Index 0 is the first synchroniser stage, index 2 the edge-detect delay.
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      ncs_sync  <= 3'b111;
      spck_sync <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      ncs_sync  <= {ncs_sync[1:0], ncs};
      spck_sync <= {spck_sync[1:0], spck};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign spck_rise =  spck_sync[1] & ~spck_sync[2];
  assign ncs_fall  = ~ncs_sync[1]  &  ncs_sync[2];
  assign ncs_rise  =  ncs_sync[1]  & ~ncs_sync[2];

  // The ncs flops reset high, so a chip select already low at reset release
  // looks like a falling edge. Frames start only after ncs is seen truly high.
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      live  <= 1'b0;
      armed <= 1'b0;
    end else begin
      live  <= 1'b1;
      armed <= armed | (live & ncs_sync[0]);
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state <= IDLE;
      shreg <= 16'h0000;
      cnt   <= 5'd0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall && armed) begin
          state_next = SHIFT;
          shreg_next = 16'h0000;
          cnt_next   = 5'd0;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end else if (ncs_fall) begin
          shreg_next = 16'h0000;
          cnt_next   = 5'd0;
        end else if (spck_rise) begin
          shreg_next = {shreg[14:0], mosi_sync[1]};
          cnt_next   = (cnt == CNT_SAT) ? cnt : cnt + 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign opcode   = shreg[15:12];
  assign len_ok   = (cnt == CNT_FULL);
  assign op_known = (opcode == OP_SET_CONF) || (opcode == OP_SET_DIVISOR) ||
                    (opcode == OP_SET_THRESH);
  assign accept   = frame_done &  (len_ok & op_known);
  assign reject   = frame_done & ~(len_ok & op_known);

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      major_mode <= 4'h0;
      minor_mode <= 4'h0;
      divisor    <= DIV_RESET;
      threshold  <= THR_RESET;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_valid <= accept;
      frame_err <= reject;
      if (accept) begin
        case (opcode)
          OP_SET_CONF: begin
            major_mode <= shreg[3:0];
            minor_mode <= shreg[7:4];
          end
          OP_SET_DIVISOR: divisor   <= shreg[7:0];
          OP_SET_THRESH:  threshold <= shreg[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpga_cmd_decoder.sv
// Directed bench for fpga_cmd_decoder: SPI frames driven bit by bit, results
// checked against hand-computed values with immediate assertions.
`default_nettype none

module tb_fpga_cmd_decoder;

  logic       clk;
  logic       rst;
  logic       ncs;
  logic       spck;
  logic       mosi;
  logic [3:0] major_mode;
  logic [3:0] minor_mode;
  logic [7:0] divisor;
  logic [7:0] threshold;
  logic       cmd_valid;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;

  int         cv_cnt;
  int         fe_cnt;
  int         cv_at;
  logic [3:0] major_at_cv;
  logic [7:0] div_at_cv;
  logic [7:0] thr_at_cv;

  fpga_cmd_decoder #(
    .DIV_RESET(8'd95),
    .THR_RESET(8'd127)
  ) dut (
    .ck_1356meg(clk),
    .rst       (rst),
    .ncs       (ncs),
    .spck      (spck),
    .mosi      (mosi),
    .major_mode(major_mode),
    .minor_mode(minor_mode),
    .divisor   (divisor),
    .threshold (threshold),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #37 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic start_frame();
    ncs = 1'b0;
    wait_cycles(4);
  endtask

  // Shifts out bits[n-1] first down to bits[0].
  task automatic send_bits(input logic [16:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      wait_cycles(3);
      spck = 1'b1;
      wait_cycles(3);
      spck = 1'b0;
    end
    wait_cycles(3);
  endtask

  // Raises ncs and watches 10 cycles for pulses; cv_at is the negedge index
  // (1-based) of the first cmd_valid.
  task automatic end_frame();
    cv_cnt      = 0;
    fe_cnt      = 0;
    cv_at       = 0;
    major_at_cv = 4'hx;
    div_at_cv   = 8'hxx;
    thr_at_cv   = 8'hxx;
    ncs = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        cv_cnt++;
        if (cv_at == 0) begin
          cv_at       = i;
          major_at_cv = major_mode;
          div_at_cv   = divisor;
          thr_at_cv   = threshold;
        end
      end
      if (frame_err === 1'b1) fe_cnt++;
    end
  endtask

  initial begin
    rst  = 1'b1;
    ncs  = 1'b1;
    spck = 1'b0;
    mosi = 1'b0;
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(5);

    chk("reset_major",     32'(major_mode), 32'd0);
    chk("reset_minor",     32'(minor_mode), 32'd0);
    chk("reset_divisor",   32'(divisor),    32'd95);
    chk("reset_threshold", 32'(threshold),  32'd127);
    chk("reset_cmd_valid", 32'(cmd_valid),  32'd0);
    chk("reset_frame_err", 32'(frame_err),  32'd0);

    // SET_CONF 0x1035
    start_frame();
    send_bits({1'b0, 16'h1035}, 16);
    end_frame();
    chk("conf_cv_count",  32'(cv_cnt),      32'd1);
    chk("conf_fe_count",  32'(fe_cnt),      32'd0);
    chk("conf_cv_timing", 32'(cv_at),       32'd3);
    chk("conf_major_at",  32'(major_at_cv), 32'd5);
    chk("conf_minor",     32'(minor_mode),  32'd3);
    chk("conf_divisor",   32'(divisor),     32'd95);

    // SET_DIVISOR 0x2058
    start_frame();
    send_bits({1'b0, 16'h2058}, 16);
    end_frame();
    chk("div_cv_count", 32'(cv_cnt),    32'd1);
    chk("div_fe_count", 32'(fe_cnt),    32'd0);
    chk("div_value_at", 32'(div_at_cv), 32'd88);
    chk("div_major",    32'(major_mode), 32'd5);

    // SET_THRESH 0x30C0
    start_frame();
    send_bits({1'b0, 16'h30C0}, 16);
    end_frame();
    chk("thr_cv_count", 32'(cv_cnt),    32'd1);
    chk("thr_value_at", 32'(thr_at_cv), 32'd192);
    chk("thr_major",    32'(major_mode), 32'd5);
    chk("thr_divisor",  32'(divisor),    32'd88);

    // 15-bit SET_CONF frame (leading 15 bits of 0x10A9)
    start_frame();
    send_bits({2'b00, 15'h0854}, 15);
    end_frame();
    chk("len15_fe_count", 32'(fe_cnt),     32'd1);
    chk("len15_cv_count", 32'(cv_cnt),     32'd0);
    chk("len15_major",    32'(major_mode), 32'd5);
    chk("len15_minor",    32'(minor_mode), 32'd3);

    // 17-bit SET_CONF frame (0x10A9 plus a trailing bit)
    start_frame();
    send_bits({16'h10A9, 1'b0}, 17);
    end_frame();
    chk("len17_fe_count", 32'(fe_cnt),     32'd1);
    chk("len17_cv_count", 32'(cv_cnt),     32'd0);
    chk("len17_major",    32'(major_mode), 32'd5);

    // Unknown opcode 0x7FFF
    start_frame();
    send_bits({1'b0, 16'h7FFF}, 16);
    end_frame();
    chk("badop_fe_count",  32'(fe_cnt),     32'd1);
    chk("badop_cv_count",  32'(cv_cnt),     32'd0);
    chk("badop_major",     32'(major_mode), 32'd5);
    chk("badop_minor",     32'(minor_mode), 32'd3);
    chk("badop_divisor",   32'(divisor),    32'd88);
    chk("badop_threshold", 32'(threshold),  32'd192);

    // Reset in the middle of 0x1035, frame then completed and closed
    start_frame();
    send_bits({9'h000, 8'h10}, 8);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    send_bits({9'h000, 8'h35}, 8);
    end_frame();
    chk("midrst_cv_count",  32'(cv_cnt),     32'd0);
    chk("midrst_fe_count",  32'(fe_cnt),     32'd0);
    chk("midrst_major",     32'(major_mode), 32'd0);
    chk("midrst_minor",     32'(minor_mode), 32'd0);
    chk("midrst_divisor",   32'(divisor),    32'd95);
    chk("midrst_threshold", 32'(threshold),  32'd127);

    // Normal operation resumes on the next frame
    wait_cycles(4);
    start_frame();
    send_bits({1'b0, 16'h1035}, 16);
    end_frame();
    chk("after_cv_count", 32'(cv_cnt),     32'd1);
    chk("after_major",    32'(major_mode), 32'd5);
    chk("after_minor",    32'(minor_mode), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
